updown_mode_counter: RTL and testbench
======================================

# updown_mode_counter

Parametrised synchronous counter generalising the lab's fixed 4-bit down counter: configurable width and terminal value, runtime-selectable up, down, bounce (ascend then descend) or hold mode, synchronous load, count enable, and wrap-or-saturate behaviour. It is the reusable count/timebase primitive for later lab blocks (sequencers, dividers, LED patterns). All outputs are registered.

## Interface
- WIDTH, 4, counter width in bits (>= 2)
- MAX, 2**WIDTH-1, terminal (highest) count value; 1 <= MAX <= 2**WIDTH-1
- SATURATE, 0, 1 = hold at terminal value in up/down modes; 0 = wrap around

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low (one clock; `rst` asserted low clears all state immediately)
- en  in  1  count enable; step taken on a rising clk edge only when high
- mode  in  2  00 up, 01 down, 10 bounce, 11 hold
- load  in  1  synchronous load strobe; overrides en and mode
- load_val  in  WIDTH  value to load
- out  out  WIDTH  current count
- dir  out  1  current direction, 1 = up, 0 = down
- tc  out  1  terminal-count pulse, registered

## Operation
- Reset (rst low): out = 0, dir = 1, tc = 0, regardless of clk.
- Priority per edge: load > (en and mode) > idle.
- Load: out <= min(load_val, MAX); tc <= 0. dir <= 1 if loaded value is 0, dir <= 0 if loaded value is MAX, else unchanged.
- en low, or mode = hold: out and dir unchanged, tc <= 0.
- Up (en=1): dir <= 1. out < MAX: out+1. out == MAX: 0 if SATURATE=0, else hold MAX.
- Down (en=1): dir <= 0. out > 0: out-1. out == 0: MAX if SATURATE=0, else hold 0.
- Bounce (en=1), SATURATE ignored: dir=1 and out < MAX: out+1; dir=1 and out == MAX: out <= MAX-1, dir <= 0; dir=0 and out > 0: out-1; dir=0 and out == 0: out <= 1, dir <= 1. Period 2*MAX cycles; endpoints visited once per turn.
- tc <= 1 on an enabled, non-load step where out was at the mode's terminal value before the edge: up at MAX, down at 0, bounce at MAX with dir=1 or at 0 with dir=0. Otherwise tc <= 0. Under saturation with en held, tc stays high every cycle.
- Mode change: takes effect on the next edge from the current out value; no reset of count. Up/down force dir; entering bounce uses stored dir.
- out never exceeds MAX (load clamps); arithmetic is modulo within [0, MAX], not 2**WIDTH.

## Timing
- Single-cycle latency: inputs sampled at rising clk, out/dir/tc update at that edge.
- tc is high for the cycle following the terminal step, aligned with the wrapped/reversed out value.
- Reset assertion asynchronous; deassertion assumed synchronised upstream; first step occurs on the first rising edge with rst high.
- Reset mid-count: out returns to 0, dir to 1, tc to 0 within the same cycle; no pending state survives.

## Structure
- Shared package `counter_pkg`: mode encodings MODE_UP, MODE_DOWN, MODE_BOUNCE, MODE_HOLD (2-bit).
- Single module; next-state logic in one combinational block, one registered always block for out/dir/tc. No sub-module.

## Test plan
- Reset/up wrap (WIDTH=4, MAX=15, SATURATE=0): rst low then high, mode=00, en=1 for 17 cycles -> out 0..15, 0, 1; tc high exactly in the cycle out shows 0 after 15.
- Down saturate (MAX=9, SATURATE=1): load 3, mode=01, en=1 for 5 cycles -> out 3,2,1,0,0,0; dir=0; tc high in both cycles after the first hold at 0.
- Bounce (MAX=15): from reset, mode=10, en=1 for 32 cycles -> out 0..15..0 and back to 1 by cycle 31 start of second ascent; dir falls when out goes 15->14, rises when 0->1; tc pulses after each endpoint.
- Load priority/clamp (MAX=9): load=1, en=1, load_val=12 -> out=9, dir=0, tc=0; next cycle load_val=0 with load -> out=0, dir=1.
- Enable/hold: mid-count at out=6, en=0 for 3 cycles then mode=11 with en=1 for 3 cycles -> out stays 6, tc=0 throughout.
- Async reset mid-operation: at out=11 in bounce descending, pull rst low between edges -> out=0, dir=1, tc=0 immediately; release -> counting resumes from 0 upward.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: mode encodings shared by the lab counter/timebase blocks.
package counter_pkg;

   typedef enum logic [1:0] {
      MODE_UP     = 2'b00,
      MODE_DOWN   = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_HOLD   = 2'b11
   } mode_e;

endpackage

// File: rtl/updown_mode_counter.sv
// updown_mode_counter: parametrised up/down/bounce/hold counter with load, enable,
// wrap-or-saturate and a registered terminal-count pulse.
module updown_mode_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MAX      = 2**WIDTH-1,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             dir,
   output logic             tc
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO  = '0;

   logic [WIDTH-1:0] out_q, out_d, load_clamped;
   logic             dir_q, dir_d, tc_q, tc_d;
   logic             at_top, at_bot, step;

   assign at_top       = out_q == MAX_V;
   assign at_bot       = out_q == ZERO;
   assign load_clamped = load_val > MAX_V ? MAX_V : load_val;
   assign step         = en && mode != MODE_HOLD;

   always_comb begin
      out_d = out_q;
      dir_d = dir_q;
      tc_d  = 1'b0;
      if (load) begin
         out_d = load_clamped;
         dir_d = load_clamped == ZERO ? 1'b1 : load_clamped == MAX_V ? 1'b0 : dir_q;
      end else if (step && mode == MODE_UP) begin
         dir_d = 1'b1;
         tc_d  = at_top;
         out_d = !at_top ? out_q + ONE : SATURATE ? MAX_V : ZERO;
      end else if (step && mode == MODE_DOWN) begin
         dir_d = 1'b0;
         tc_d  = at_bot;
         out_d = !at_bot ? out_q - ONE : SATURATE ? ZERO : MAX_V;
      end else if (step && mode == MODE_BOUNCE) begin
         // Reflect at an endpoint: flip direction and step away from it in one edge.
         tc_d  = dir_q ? at_top : at_bot;
         dir_d = tc_d ? !dir_q : dir_q;
         out_d = dir_d ? out_q + ONE : out_q - ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q <= ZERO;
         dir_q <= 1'b1;
         tc_q  <= 1'b0;
      end else begin
         out_q <= out_d;
         dir_q <= dir_d;
         tc_q  <= tc_d;
      end
   end

   assign out = out_q;
   assign dir = dir_q;
   assign tc  = tc_q;

endmodule

// File: tb/tb_updown_mode_counter.sv
// tb_updown_mode_counter: randomized + directed check of two counter configurations
// (wrapping MAX=15, saturating MAX=9) against an arithmetic reference model.
module tb_updown_mode_counter;

   logic       clk = 1'b0, rst = 1'b0, en = 1'b0, load = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [3:0] load_val = 4'd0;
   logic [3:0] out_w, out_s;
   logic       dir_w, dir_s, tc_w, tc_s;

   int n_cmp = 0, n_bad = 0;
   int mx[2]  = '{15, 9};
   bit sat[2] = '{1'b0, 1'b1};
   int m_out[2], m_dir[2], m_tc[2];

   always #5 clk = ~clk;

   updown_mode_counter #(.WIDTH(4), .MAX(15), .SATURATE(1'b0)) dut_w (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
      .out(out_w), .dir(dir_w), .tc(tc_w));

   updown_mode_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b1)) dut_s (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
      .out(out_s), .dir(dir_s), .tc(tc_s));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic reset_models();
      for (int k = 0; k < 2; k++) begin
         m_out[k] = 0;
         m_dir[k] = 1;
         m_tc[k]  = 0;
      end
   endtask

   // Behavioural rules: modular arithmetic over [0, MAX], bounce reflects at ends.
   task automatic model_step(input int k);
      int m, v;
      m = mx[k];
      if (load) begin
         v = (int'(load_val) > m) ? m : int'(load_val);
         m_out[k] = v;
         m_tc[k]  = 0;
         if (v == 0) m_dir[k] = 1;
         else if (v == m) m_dir[k] = 0;
      end else if (!en || mode == 2'b11) begin
         m_tc[k] = 0;
      end else if (mode == 2'b00) begin
         m_tc[k]  = (m_out[k] == m);
         m_dir[k] = 1;
         m_out[k] = (sat[k] && m_out[k] == m) ? m : (m_out[k] + 1) % (m + 1);
      end else if (mode == 2'b01) begin
         m_tc[k]  = (m_out[k] == 0);
         m_dir[k] = 0;
         m_out[k] = (sat[k] && m_out[k] == 0) ? 0 : (m_out[k] + m) % (m + 1);
      end else begin
         m_tc[k] = m_dir[k] ? (m_out[k] == m) : (m_out[k] == 0);
         if (m_tc[k] != 0) m_dir[k] = 1 - m_dir[k];
         m_out[k] = m_dir[k] ? m_out[k] + 1 : m_out[k] - 1;
      end
   endtask

   task automatic check_all();
      check("w_out", 32'(out_w), 32'(m_out[0]));
      check("w_dir", 32'(dir_w), 32'(m_dir[0]));
      check("w_tc",  32'(tc_w),  32'(m_tc[0]));
      check("s_out", 32'(out_s), 32'(m_out[1]));
      check("s_dir", 32'(dir_s), 32'(m_dir[1]));
      check("s_tc",  32'(tc_s),  32'(m_tc[1]));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_all();
   endtask

   // Called 1 time unit after an edge: pull reset low mid-cycle, check, release.
   task automatic pulse_reset();
      #2 rst = 1'b0;
      #1;
      check("arst_out", 32'(out_w), 32'd0);
      check("arst_dir", 32'(dir_w), 32'd1);
      check("arst_tc",  32'(tc_s),  32'd0);
      reset_models();
      check_all();
      #1 rst = 1'b1;
   endtask

   initial begin
      reset_models();
      #12;
      check("rst_out", 32'(out_w), 32'd0);
      check("rst_dir", 32'(dir_w), 32'd1);
      check("rst_tc",  32'(tc_w),  32'd0);
      @(negedge clk) rst = 1'b1;
      mode = 2'b00;
      en   = 1'b1;
      repeat (15) tick();
      check("up_top", 32'(out_w), 32'd15);
      tick();
      check("up_wrap", 32'(out_w), 32'd0);
      check("up_wrap_tc", 32'(tc_w), 32'd1);
      load = 1'b1;
      load_val = 4'd12;
      tick();
      check("ld_clamp", 32'(out_s), 32'd9);
      check("ld_dir", 32'(dir_s), 32'd0);
      check("ld_tc", 32'(tc_s), 32'd0);
      load_val = 4'd0;
      tick();
      check("ld_zero", 32'(out_s), 32'd0);
      check("ld_zero_dir", 32'(dir_s), 32'd1);
      load_val = 4'd3;
      tick();
      load = 1'b0;
      mode = 2'b01;
      repeat (5) tick();
      check("dn_sat", 32'(out_s), 32'd0);
      check("dn_sat_tc", 32'(tc_s), 32'd1);
      load = 1'b1;
      load_val = 4'd6;
      tick();
      load = 1'b0;
      en = 1'b0;
      repeat (3) tick();
      mode = 2'b11;
      en = 1'b1;
      repeat (3) tick();
      check("hold_out", 32'(out_s), 32'd6);
      pulse_reset();
      mode = 2'b10;
      repeat (32) tick();
      check("bnc_cycle", 32'(out_w), 32'd2);
      repeat (3000) begin
         load     = ($urandom_range(0, 9) == 0);
         load_val = 4'($urandom);
         en       = ($urandom_range(0, 3) != 0);
         mode     = 2'($urandom);
         if ($urandom_range(0, 99) == 0) pulse_reset();
         tick();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
